audio_i2s_tx: RTL and testbench

// - I2S serial transmitter downstream of AUDIO_channel.
// - Latches one 16-bit left/right sample pair per frame and drives BCLK, LRCK and SDATA to the external DAC.
// - Generates the frame-rate o_sample_clock square wave, which drives the channel's i_output_sample_clock.

---
 rtl/audio_i2s_tx.sv | 173 +++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx -- I2S serial transmitter feeding an external DAC.
//
// Latches one 16-bit signed left/right pair at each frame start and shifts
// it out MSB first as standard I2S: one-BCLK delay after the LRCK edge, and
// each 16-bit word zero-padded to a 32-bit slot. It also produces the
// frame-rate square wave o_sample_clock; its rising edge marks the frame
// start and paces the upstream channel.
//
// Frame = 64 BCLK periods = 128*BCLK_DIV i_clock cycles.
//
// Parameters
//   BCLK_DIV        i_clock cycles per BCLK half-period (>= 2)
// Ports
//   i_clock         system clock, all logic on posedge
//   i_reset         synchronous, active-high reset
//   i_enable        1 = run, 0 = idle (all outputs low)
//   i_sample_left   signed left sample, latched at frame start
//   i_sample_right  signed right sample, latched at frame start
//   o_sample_clock  high for slots 0..31, low for slots 32..63
//   o_i2s_bclk      bit clock, idles low
//   o_i2s_lrck      word select, 0 = left, 1 = right
//   o_i2s_sdata     serial data, changes only on the BCLK falling edge
//
// Build option
//   AUDIO_I2S_TX_MONO_EN  when defined, both channels carry (L+R)>>>1.

module audio_i2s_tx #(
  parameter int BCLK_DIV = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_sample_left,
  input  logic [15:0] i_sample_right,
  output logic        o_sample_clock,
  output logic        o_i2s_bclk,
  output logic        o_i2s_lrck,
  output logic        o_i2s_sdata
);

  localparam int            DW      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt;
  logic [5:0]    slot;
  logic          bclk, lrck, sdata, sclk;
  logic [15:0]   hold_l, hold_r;
  // Left word minus its MSB (sent directly from hold_l in slot 1) followed
  // by the full right word; shifted once per data slot.
  logic [30:0]   shreg;

  logic          tick, fall, frame_start;
  logic [5:0]    slot_nx;
  logic          data_slot;
  logic [15:0]   lat_l, lat_r;

  // Values captured into the holding registers at frame start.
`ifdef AUDIO_I2S_TX_MONO_EN
  // 17-bit signed sum; dropping bit 0 is the floor arithmetic shift by 1,
  // keeping bits 16:1 truncates the result back to 16 bits.
  logic [16:0] mono_sum;
  assign mono_sum = {i_sample_left[15], i_sample_left}
                  + {i_sample_right[15], i_sample_right};
  assign lat_l    = mono_sum[16:1];
  assign lat_r    = mono_sum[16:1];
`else
  assign lat_l    = i_sample_left;
  assign lat_r    = i_sample_right;
`endif

  assign slot_nx   = slot + 6'd1;
  // Slot 1 is loaded specially; these slots take the next shifted bit.
  assign data_slot = ((slot_nx >= 6'd2)  && (slot_nx <= 6'd16)) ||
                     ((slot_nx >= 6'd33) && (slot_nx <= 6'd48));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    tick        = 1'b0;
    fall        = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else begin
          tick        = (div_cnt == DIV_MAX);
          fall        = tick && bclk;
          // Falling edge out of slot 63 is the next frame start.
          frame_start = fall && (slot == 6'd63);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Divider, slot counter and serializer
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div_cnt <= '0;
      slot    <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
      sdata   <= 1'b0;
      sclk    <= 1'b0;
      shreg   <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
    end else if (state_d == IDLE) begin
      // Idle or leaving RUN: outputs low, counters cleared, so a later
      // enable always starts a fresh frame.
      div_cnt <= '0;
      slot    <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
      sdata   <= 1'b0;
      sclk    <= 1'b0;
      shreg   <= '0;
    end else if (frame_start) begin
      div_cnt <= '0;
      slot    <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
      sdata   <= 1'b0;
      sclk    <= 1'b1;
      hold_l  <= lat_l;
      hold_r  <= lat_r;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
      if (fall) begin
        slot <= slot_nx;
        lrck <= slot_nx[5];
        sclk <= ~slot_nx[5];
        if (slot_nx == 6'd1) begin
          sdata <= hold_l[15];
          shreg <= {hold_l[14:0], hold_r};
        end else if (data_slot) begin
          sdata <= shreg[30];
          shreg <= {shreg[29:0], 1'b0};
        end else begin
          sdata <= 1'b0;
        end
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign o_sample_clock = sclk;
  assign o_i2s_bclk     = bclk;
  assign o_i2s_lrck     = lrck;
  assign o_i2s_sdata    = sdata;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx at BCLK_DIV=2. Expected frame words are queued when
// the sample pair is driven and popped when a captured frame completes.
module tb_audio_i2s_tx;

  localparam int BCLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] sl, sr;
  logic        sclk, bclk, lrck, sdata;

  int checks = 0;
  int passes = 0;

  logic [31:0] sb[$];

  // edge flags, refreshed by step() on every falling clock edge
  logic b_rise, b_fall, s_rise, s_fall, l_fall;
  logic pb = 1'b0, ps = 1'b0, pl = 1'b0;

  always #5 clk = ~clk;

  audio_i2s_tx #(.BCLK_DIV(BCLK_DIV)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_sample_left  (sl),
    .i_sample_right (sr),
    .o_sample_clock (sclk),
    .o_i2s_bclk     (bclk),
    .o_i2s_lrck     (lrck),
    .o_i2s_sdata    (sdata)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Expected {left, right} words on the wire for one latched pair.
  function automatic logic [31:0] model(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_I2S_TX_MONO_EN
    int s;
    logic [15:0] m;
    s = (int'($signed(l)) + int'($signed(r))) >>> 1;
    m = 16'(s);
    return {m, m};
`else
    return {l, r};
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    b_rise = bclk & ~pb;
    b_fall = ~bclk & pb;
    s_rise = sclk & ~ps;
    s_fall = ~sclk & ps;
    l_fall = ~lrck & pl;
    pb = bclk;
    ps = sclk;
    pl = lrck;
  endtask

  task automatic wait_sclk_rise(output bit to);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (s_rise) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_bfalls(input int n, output bit to);
    int k;
    k = 0;
    for (int i = 0; i < 4000 && k < n; i++) begin
      step();
      if (b_fall) k++;
    end
    to = (k != n);
  endtask

  // Call right after the step that saw o_sample_clock rise (slot 0).
  // Samples sdata/lrck on each BCLK rise; optionally rewrites the left
  // input when slot chg_slot is reached.
  task automatic capture(input int chg_slot, input logic [15:0] chg_val,
                         output logic [31:0] word, output bit pad_err,
                         output bit lr_err, output bit to);
    int s;
    s = 0; word = '0; pad_err = 1'b0; lr_err = 1'b0;
    for (int i = 0; i < 2000 && s < 64; i++) begin
      step();
      if (b_rise) begin
        if ((s >= 1 && s <= 16) || (s >= 33 && s <= 48)) word = {word[30:0], sdata};
        else if (sdata !== 1'b0) pad_err = 1'b1;
        if (lrck !== (s >= 32)) lr_err = 1'b1;
        if (s == chg_slot) sl = chg_val;
        s++;
      end
    end
    to = (s != 64);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sl = 16'hFFFF; sr = 16'hFFFF;
    repeat (3) step();
    checks++;
    if ({sclk, bclk, lrck, sdata} !== 4'b0000)
      $display("FAIL reset_outputs: got %b required 0000", {sclk, bclk, lrck, sdata});
    else passes++;
    rst = 1'b0; en = 1'b0;
    repeat (6) step();
    checks++;
    if ({sclk, bclk, lrck, sdata} !== 4'b0000)
      $display("FAIL idle_outputs: got %b required 0000", {sclk, bclk, lrck, sdata});
    else passes++;
  endtask

  task automatic test_frame();
    logic [31:0] w, e;
    bit pe, le, to, to2;
    sl = 16'hA5C3; sr = 16'h8001;
    sb.push_back(model(sl, sr));
    en = 1'b1;
    wait_sclk_rise(to);
    capture(-1, 16'h0, w, pe, le, to2);
    e = sb.pop_front();
    checks++;
    if (to || to2) $display("FAIL frame_timeout: got timeout required frame");
    else passes++;
    checks++;
    if (w !== e) $display("FAIL frame_data: got %h required %h", w, e);
    else passes++;
    checks++;
    if (pe !== 1'b0) $display("FAIL frame_padding: got nonzero pad bit required 0");
    else passes++;
    checks++;
    if (le !== 1'b0) $display("FAIL frame_lrck: got wrong lrck in some slot required slot>=32");
    else passes++;
  endtask

  task automatic test_timing();
    bit to;
    int n, hi, per;
    wait_sclk_rise(to);
    checks++;
    if (to || !l_fall) $display("FAIL sclk_lrck_align: got lrck_fall=%0b to=%0b required 1/0", l_fall, to);
    else passes++;
    n = 0; hi = -1;
    for (int i = 0; i < 1000; i++) begin
      step(); n++;
      if (s_fall) hi = n;
      if (s_rise) break;
    end
    checks++;
    if (hi !== 128) $display("FAIL sclk_high: got %0d required 128", hi);
    else passes++;
    checks++;
    if (n !== 256) $display("FAIL sclk_period: got %0d required 256", n);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b_rise) break;
    end
    per = 0;
    for (int i = 0; i < 20; i++) begin
      step(); per++;
      if (b_rise) break;
    end
    checks++;
    if (per !== 2 * BCLK_DIV) $display("FAIL bclk_period: got %0d required %0d", per, 2 * BCLK_DIV);
    else passes++;
  endtask

  task automatic test_midchange();
    logic [31:0] w, e;
    bit pe, le, to, to2;
    sl = 16'h1234; sr = 16'h0F0F;
    sb.push_back(model(sl, sr));
    wait_sclk_rise(to);
    capture(5, 16'hFFFF, w, pe, le, to2);
    e = sb.pop_front();
    checks++;
    if (to || to2 || w !== e) $display("FAIL midchange_cur: got %h required %h", w, e);
    else passes++;
    sb.push_back(model(16'hFFFF, 16'h0F0F));
    wait_sclk_rise(to);
    capture(-1, 16'h0, w, pe, le, to2);
    e = sb.pop_front();
    checks++;
    if (to || to2 || w !== e) $display("FAIL midchange_next: got %h required %h", w, e);
    else passes++;
  endtask

  task automatic test_enable_drop();
    logic [31:0] w, e;
    bit pe, le, to, to2, nz;
    sl = 16'h5A5A; sr = 16'h00FF;
    wait_sclk_rise(to);
    wait_bfalls(40, to2);
    checks++;
    if (to || to2) $display("FAIL drop_reach_slot40: got timeout required slot 40");
    else passes++;
    en = 1'b0;
    step();
    checks++;
    if ({sclk, bclk, lrck, sdata} !== 4'b0000)
      $display("FAIL drop_outputs: got %b required 0000", {sclk, bclk, lrck, sdata});
    else passes++;
    nz = 1'b0;
    repeat (9) begin
      step();
      if ({sclk, bclk, lrck, sdata} !== 4'b0000) nz = 1'b1;
    end
    checks++;
    if (nz) $display("FAIL drop_idle_hold: got activity required all 0");
    else passes++;
    sl = 16'h0C3F; sr = 16'hF00D;
    sb.push_back(model(sl, sr));
    en = 1'b1;
    step();
    checks++;
    if (!s_rise || bclk !== 1'b0) $display("FAIL drop_restart: got s_rise=%0b bclk=%b required 1/0", s_rise, bclk);
    else passes++;
    capture(-1, 16'h0, w, pe, le, to);
    e = sb.pop_front();
    checks++;
    if (to || pe || le || w !== e) $display("FAIL drop_frame: got %h required %h", w, e);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, e;
    bit pe, le, to, to2;
    wait_sclk_rise(to);
    wait_bfalls(20, to2);
    rst = 1'b1;
    step();
    checks++;
    if (to || to2 || {sclk, bclk, lrck, sdata} !== 4'b0000)
      $display("FAIL midreset_outputs: got %b required 0000", {sclk, bclk, lrck, sdata});
    else passes++;
    repeat (2) step();
    sl = 16'h6D29; sr = 16'h9E17;
    sb.push_back(model(sl, sr));
    rst = 1'b0;
    step();
    checks++;
    if (!s_rise) $display("FAIL midreset_restart: got s_rise=%0b required 1", s_rise);
    else passes++;
    capture(-1, 16'h0, w, pe, le, to);
    e = sb.pop_front();
    checks++;
    if (to || pe || le || w !== e) $display("FAIL midreset_frame: got %h required %h", w, e);
    else passes++;
  endtask

  task automatic test_mono();
    logic [31:0] w, e;
    bit pe, le, to, to2;
    logic [15:0] vl [2];
    logic [15:0] vr [2];
    vl[0] = 16'h7FFF; vr[0] = 16'h0001;
    vl[1] = 16'h8000; vr[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      sl = vl[k]; sr = vr[k];
      sb.push_back(model(sl, sr));
      wait_sclk_rise(to);
      capture(-1, 16'h0, w, pe, le, to2);
      e = sb.pop_front();
      checks++;
      if (to || to2 || w !== e) $display("FAIL mono_vec%0d: got %h required %h", k, w, e);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sl = '0; sr = '0;
    test_reset();
    test_frame();
    test_timing();
    test_midchange();
    test_enable_drop();
    test_reset_mid();
    test_mono();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
